// File: rtl/rotsq_pkg.sv
// Shared types and defaults for the rotating-square step sequencer.
package rotsq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } rotsq_state_e;

  localparam int DEF_DIV_W = 24;
  localparam int DEF_CNT_W = 8;

  // Divisor for one step per 0.1 s from a 100 MHz clock.
  localparam logic [DEF_DIV_W-1:0] DEF_DIV_100MS = 24'd9_999_999;

endpackage

// File: rtl/rotsq_prescaler.sv
// Step-period counter: counts 0..i_term while not held, wrapping to 0;
// o_wrap flags the wrapping clock, o_tick is its registered copy.
module rotsq_prescaler
  import rotsq_pkg::*;
#(
  parameter int P_DIV_W = DEF_DIV_W
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_clr,
  input  logic               i_hold,
  input  logic [P_DIV_W-1:0] i_term,
  output logic               o_wrap,
  output logic               o_tick
);

  logic [P_DIV_W-1:0] cnt_r;

  assign o_wrap = !i_clr && !i_hold && (cnt_r == i_term);

  // Counter and registered wrap tick.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_r  <= '0;
      o_tick <= 1'b0;
    end else begin
      o_tick <= o_wrap;
      if (i_clr || o_wrap) begin
        cnt_r <= '0;
      end else if (!i_hold) begin
        cnt_r <= cnt_r + P_DIV_W'(1'b1);
      end
    end
  end

endmodule

// File: rtl/rotsq_step_ctrl.sv
// Step sequencer for the rotating-square pattern: issues one-cycle step
// enables and direction, continuous or for a programmed step count.
module rotsq_step_ctrl
  import rotsq_pkg::*;
#(
  parameter int P_DIV_W = DEF_DIV_W,
  parameter int P_CNT_W = DEF_CNT_W
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic               i_stop,
  input  logic               i_pause,
  input  logic               i_cw_req,
  input  logic [P_DIV_W-1:0] i_div,
  input  logic [P_CNT_W-1:0] i_steps,
  output logic               o_en,
  output logic               o_cw,
  output logic               o_busy,
  output logic               o_done,
  output logic [P_CNT_W-1:0] o_steps_left
);

  rotsq_state_e       state_r;
  rotsq_state_e       state_nxt_s;
  logic [P_DIV_W-1:0] div_r;
  logic [P_CNT_W-1:0] steps_r;
  logic               busy_s;
  logic               start_ok_s;
  logic               clr_s;
  logic               hold_s;
  logic               wrap_s;
  logic               last_s;

  assign busy_s     = (state_r == ST_RUN) || (state_r == ST_PAUSE);
  assign start_ok_s = (state_r == ST_IDLE) && i_start && !i_stop;
  // Stop clears the prescaler, which also suppresses a coincident wrap.
  assign clr_s      = !busy_s || i_stop;
  assign hold_s     = i_pause;
  assign last_s     = (steps_r != '0) && (o_steps_left == P_CNT_W'(1'b1));

  rotsq_prescaler #(
    .P_DIV_W (P_DIV_W)
  ) u_prescaler (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_clr  (clr_s),
    .i_hold (hold_s),
    .i_term (div_r),
    .o_wrap (wrap_s),
    .o_tick (o_en)
  );

  // Next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_ok_s) state_nxt_s = ST_RUN;
        else            state_nxt_s = ST_IDLE;
      end
      ST_RUN, ST_PAUSE: begin
        if (i_stop)                state_nxt_s = ST_IDLE;
        else if (wrap_s && last_s) state_nxt_s = ST_DONE;
        else if (i_pause)          state_nxt_s = ST_PAUSE;
        else                       state_nxt_s = ST_RUN;
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State, latched run settings, direction and step bookkeeping.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r      <= ST_IDLE;
      div_r        <= '0;
      steps_r      <= '0;
      o_cw         <= 1'b1;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_steps_left <= '0;
    end else begin
      state_r <= state_nxt_s;
      // Busy stays up through the cycle that carries the final step.
      o_busy  <= (state_nxt_s != ST_IDLE) && (state_r != ST_DONE);
      o_done  <= (state_r == ST_DONE);
      if (start_ok_s) begin
        div_r        <= i_div;
        steps_r      <= i_steps;
        o_cw         <= i_cw_req;
        o_steps_left <= i_steps;
      end else if (busy_s && i_stop) begin
        o_steps_left <= '0;
      end else if (wrap_s) begin
        o_cw <= i_cw_req;
        if (steps_r != '0) begin
          o_steps_left <= o_steps_left - P_CNT_W'(1'b1);
        end
      end
    end
  end

endmodule

// File: tb/tb_rotsq_step_ctrl.sv
// Scoreboard bench for rotsq_step_ctrl: expected step/done events are queued
// with their cycle, direction and remaining count; a monitor checks them.
module tb_rotsq_step_ctrl;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_start;
  logic        i_stop;
  logic        i_pause;
  logic        i_cw_req;
  logic [23:0] i_div;
  logic [7:0]  i_steps;
  logic        o_en;
  logic        o_cw;
  logic        o_busy;
  logic        o_done;
  logic [7:0]  o_steps_left;

  typedef struct {
    bit         is_done;
    int         cyc;
    bit         cw;
    logic [7:0] left;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   e0;

  rotsq_step_ctrl #(
    .P_DIV_W (24),
    .P_CNT_W (8)
  ) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_start      (i_start),
    .i_stop       (i_stop),
    .i_pause      (i_pause),
    .i_cw_req     (i_cw_req),
    .i_div        (i_div),
    .i_steps      (i_steps),
    .o_en         (o_en),
    .o_cw         (o_cw),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_steps_left (o_steps_left)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cyc=%0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input bit d, input int c, input bit cw, input logic [7:0] l);
    exp_t e;
    e.is_done = d;
    e.cyc     = c;
    e.cw      = cw;
    e.left    = l;
    exp_q.push_back(e);
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge i_clk);
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge i_clk);
      if (o_en || o_done) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_out: cyc=%0d en=%0b done=%0b left=%0d", cyc, o_en, o_done, o_steps_left);
        end else begin
          e = exp_q.pop_front();
          if (o_done !== e.is_done || o_en !== !e.is_done || cyc != e.cyc ||
              o_cw !== e.cw || o_steps_left !== e.left) begin
            bad++;
            $display("FAIL scoreboard: got cyc=%0d en=%0b done=%0b cw=%0b left=%0d, want cyc=%0d done=%0b cw=%0b left=%0d",
                     cyc, o_en, o_done, o_cw, o_steps_left, e.cyc, e.is_done, e.cw, e.left);
          end
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    i_rst = 1'b1; i_start = 1'b0; i_stop = 1'b0; i_pause = 1'b0;
    i_cw_req = 1'b0; i_div = 24'd0; i_steps = 8'd0;
    fork
      monitor();
    join_none
    repeat (3) @(negedge i_clk);
    check("rst_en", o_en, 0);
    check("rst_cw", o_cw, 1);
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    check("rst_left", o_steps_left, 0);
    i_rst = 1'b0;
    @(negedge i_clk);

    // Finite run: div=3, 3 steps.
    e0 = cyc + 1;
    i_div = 24'd3; i_steps = 8'd3; i_cw_req = 1'b1; i_start = 1'b1;
    push(0, e0 + 4, 1, 8'd2);
    push(0, e0 + 8, 1, 8'd1);
    push(0, e0 + 12, 1, 8'd0);
    push(1, e0 + 13, 1, 8'd0);
    @(negedge i_clk);
    i_start = 1'b0;
    for (int k = 0; k < 16; k++) begin
      check("t1_busy", o_busy, (k < 13) ? 1 : 0);
      @(negedge i_clk);
    end
    check("t1_drain", exp_q.size(), 0);

    // Continuous, div=0, direction change, then stop.
    e0 = cyc + 1;
    i_div = 24'd0; i_steps = 8'd0; i_cw_req = 1'b1; i_start = 1'b1;
    for (int k = 1; k <= 6; k++) push(0, e0 + k, (k >= 4) ? 1'b0 : 1'b1, 8'd0);
    @(negedge i_clk);
    i_start = 1'b0;
    wait_cyc(e0 + 3);
    i_cw_req = 1'b0;
    wait_cyc(e0 + 6);
    i_stop = 1'b1;
    @(negedge i_clk);
    i_stop = 1'b0;
    check("t2_stop_busy", o_busy, 0);
    check("t2_stop_left", o_steps_left, 0);
    wait_cyc(e0 + 10);
    check("t2_drain", exp_q.size(), 0);

    // Continuous div=4: ignored restart, pause on wrap cycle, held direction.
    e0 = cyc + 1;
    i_div = 24'd4; i_steps = 8'd0; i_cw_req = 1'b1; i_start = 1'b1;
    push(0, e0 + 5, 1, 8'd0);
    push(0, e0 + 20, 1, 8'd0);
    push(0, e0 + 25, 0, 8'd0);
    push(0, e0 + 30, 0, 8'd0);
    @(negedge i_clk);
    i_start = 1'b0;
    @(negedge i_clk);
    i_start = 1'b1; i_div = 24'd1; i_steps = 8'd5;
    @(negedge i_clk);
    i_start = 1'b0;
    wait_cyc(e0 + 9);
    i_pause = 1'b1;
    wait_cyc(e0 + 12);
    check("t3_pause_busy", o_busy, 1);
    wait_cyc(e0 + 19);
    i_pause = 1'b0;
    wait_cyc(e0 + 22);
    i_cw_req = 1'b0;
    @(negedge i_clk);
    check("t3_cw_hold_a", o_cw, 1);
    @(negedge i_clk);
    check("t3_cw_hold_b", o_cw, 1);
    wait_cyc(e0 + 31);
    i_stop = 1'b1;
    @(negedge i_clk);
    i_stop = 1'b0;
    check("t3_stop_busy", o_busy, 0);
    wait_cyc(e0 + 40);
    check("t3_drain", exp_q.size(), 0);

    // Start and stop together in IDLE.
    i_div = 24'd0; i_steps = 8'd2; i_start = 1'b1; i_stop = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0; i_stop = 1'b0;
    check("t4_busy_a", o_busy, 0);
    repeat (6) @(negedge i_clk);
    check("t4_busy_b", o_busy, 0);
    check("t4_left", o_steps_left, 0);

    // Single step with stop on the final wrap.
    e0 = cyc + 1;
    i_div = 24'd2; i_steps = 8'd1; i_cw_req = 1'b1; i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    @(negedge i_clk);
    check("t5_left", o_steps_left, 1);
    check("t5_busy", o_busy, 1);
    wait_cyc(e0 + 2);
    i_stop = 1'b1;
    @(negedge i_clk);
    i_stop = 1'b0;
    check("t5_stop_busy", o_busy, 0);
    check("t5_stop_left", o_steps_left, 0);
    wait_cyc(e0 + 8);
    check("t5_drain", exp_q.size(), 0);

    // Asynchronous reset mid-run.
    e0 = cyc + 1;
    i_div = 24'd3; i_steps = 8'd5; i_cw_req = 1'b0; i_start = 1'b1;
    push(0, e0 + 4, 0, 8'd4);
    @(negedge i_clk);
    i_start = 1'b0;
    wait_cyc(e0 + 6);
    check("t6_pre_cw", o_cw, 0);
    #2;
    i_rst = 1'b1;
    #1;
    check("t6_rst_en", o_en, 0);
    check("t6_rst_cw", o_cw, 1);
    check("t6_rst_busy", o_busy, 0);
    check("t6_rst_left", o_steps_left, 0);
    @(negedge i_clk);
    i_rst = 1'b0;
    repeat (12) @(negedge i_clk);
    check("t6_post_busy", o_busy, 0);
    check("t6_drain", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rotsq_step_ctrl.md
Name: rotsq_step_ctrl

Overview:
Sequencer for the rotating-square seven-segment pattern generator. It produces the one-cycle step-enable and direction signals that the pattern datapath consumes. It runs either continuously or for a programmed number of steps, with a programmable step period, pause and stop. It sits between board-level controls (buttons/switches after debounce) and the pattern datapath.

Parameters:
P_DIV_W, 24, width of step-period divisor (clocks per step minus 1)
P_CNT_W, 8, width of step-count request and remaining-step counter

Ports:
i_clk  in  1  system clock
i_rst  in  1  reset; asynchronous, active-high
i_start  in  1  one-cycle start request; honoured only in IDLE
i_stop  in  1  one-cycle abort request; honoured in RUN/PAUSE
i_pause  in  1  level; freezes stepping while high
i_cw_req  in  1  requested direction (1 = clockwise)
i_div  in  P_DIV_W  step period minus 1, latched at start
i_steps  in  P_CNT_W  steps to run, latched at start; 0 = continuous
o_en  out  1  one-cycle step enable to pattern datapath
o_cw  out  1  direction to pattern datapath
o_busy  out  1  high in RUN or PAUSE
o_done  out  1  one-cycle pulse when a finite run completes
o_steps_left  out  P_CNT_W  remaining steps (0 in continuous mode)

Behaviour:
- All outputs registered. Reset (async, any time including mid-run): state IDLE, prescaler 0, o_en 0, o_cw 1, o_busy 0, o_done 0, o_steps_left 0, latched div/steps 0.
- FSM states: IDLE, RUN, PAUSE, DONE.
- IDLE: on i_start (with i_stop low) at edge E0: latch i_div, i_steps; o_cw <= i_cw_req; prescaler <= 0; o_steps_left <= i_steps; go RUN. i_start and i_stop together in IDLE: stay IDLE.
- RUN: prescaler increments each clock; at prescaler == div_latched it wraps to 0 and o_en is high for the following cycle. First o_en after edge E0+(div+1), then every div+1 clocks. div = 0 -> o_en high every cycle.
- Direction: o_cw <= i_cw_req only on the edge that raises o_en; otherwise held. o_cw never changes while o_en is low.
- Finite mode (steps_latched != 0): o_steps_left decrements on each edge raising o_en. The edge raising the last o_en (left 1 -> 0) moves to DONE. Next edge: o_en 0, o_done 1, o_busy 0; following edge: IDLE, o_done 0. Exactly steps_latched pulses are issued.
- Continuous mode: runs until i_stop; o_steps_left stays 0.
- RUN with i_pause high: go PAUSE on that edge. Prescaler holds and no o_en is raised. Pause has priority over a coincident wrap: that wrap is deferred, not lost.
- PAUSE with i_pause low: return to RUN; prescaler resumes from its held value.
- i_stop in RUN/PAUSE: next edge IDLE, o_en 0, o_done not pulsed, o_steps_left 0. Stop beats a coincident wrap, pause and final step.
- i_start while busy or in DONE: ignored. i_div/i_steps changes after start: no effect until next start.
- o_busy = state in {RUN, PAUSE}, registered alongside state.

Decomposition:
- Package rotsq_pkg: state enum typedef (IDLE/RUN/PAUSE/DONE), default width constants P_DIV_W/P_CNT_W, default divisor constant for 1 step per ~0.1 s.
- Sub-module rotsq_prescaler: P_DIV_W counter with clear, hold and terminal value inputs, and a registered wrap tick output. The FSM, step counter and direction register stay in the top.

Test Plan:
- Reset mid-run: assert i_rst asynchronously between edges during RUN -> outputs immediately o_en 0, o_cw 1, o_busy 0, o_steps_left 0; no o_en after release.
- i_div=3, i_steps=3, i_cw_req=1, start at E0 -> o_en high after E4, E8, E12 only; o_steps_left 2,1,0; o_done high after E13 only; o_busy low from E13.
- i_div=0, i_steps=0, start, toggle i_cw_req to 0 mid-cycle -> o_en every cycle; o_cw changes only on an o_en edge; i_stop -> o_en 0 next cycle, no o_done.
- i_div=4, continuous; raise i_pause exactly on the wrap cycle for 10 clocks -> no o_en during pause; first o_en 1 cycle after pause drops; later spacing is 5 clocks.
- Start+stop same cycle in IDLE -> stays IDLE. i_start during RUN with new i_div=1 -> ignored; period unchanged.
- i_steps=1, i_stop asserted on the edge of the final wrap -> o_en not raised, no o_done, IDLE next cycle.
